// File: rtl/ksa2_digit_serial_adder.sv
// ksa2_digit_serial_adder: digit-serial adder feeding a 2-bit Kogge-Stone slice, LSB digit first
module ksa2_digit_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int DIGITS = WIDTH / 2;
   localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   if (WIDTH < 2 || WIDTH % 2 != 0) begin : g_width_check
      $error("ksa2_digit_serial_adder: WIDTH must be even and >= 2");
   end
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] sa, sb, acc, acc_next;
   logic [CW-1:0] cnt;
   logic carry, p0, g0, p1, g1, c0, c1, last;
   logic [1:0] digit;
   always_comb begin
      p0 = sa[0] ^ sb[0];
      g0 = sa[0] & sb[0];
      p1 = sa[1] ^ sb[1];
      g1 = sa[1] & sb[1];
      c0 = g0 | (p0 & carry);
      c1 = g1 | (p1 & g0) | (p1 & p0 & carry);
      digit = {p1 ^ c0, p0 ^ carry};
      acc_next = WIDTH'({digit, acc} >> 2);
      last = cnt == CW'(DIGITS - 1);
   end
   assign in_ready = state == IDLE;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         sa <= '0;
         sb <= '0;
         acc <= '0;
         carry <= 1'b0;
         cnt <= '0;
         sum <= '0;
         cout <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               sa <= a;
               sb <= b;
               carry <= cin;
               cnt <= '0;
               state <= RUN;
            end
            RUN: begin
               sa <= sa >> 2;
               sb <= sb >> 2;
               carry <= c1;
               acc <= acc_next;
               cnt <= cnt + 1'b1;
               if (last) begin
                  sum <= acc_next;
                  cout <= c1;
                  out_valid <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ksa2_digit_serial_adder.sv
// tb_ksa2_digit_serial_adder: directed 16-bit checks plus randomized scoreboard runs at widths 2, 8, 16
module tb_ksa2_digit_serial_adder;
   localparam int NRND = 2000;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int checks = 0;
   int errors = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask
   logic rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout;
   logic [15:0] a, b, sum;
   ksa2_digit_serial_adder #(.WIDTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout)
   );
   task automatic wait_ov(output int lat, output bit irbad);
      lat = 0;
      irbad = 1'b0;
      while (!out_valid && lat < 40) begin
         if (in_ready) irbad = 1'b1;
         @(negedge clk);
         lat++;
      end
      if (in_ready) irbad = 1'b1;
   endtask
   task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic ci, output int lat, output bit irbad);
      in_valid = 1'b1;
      a = x;
      b = y;
      cin = ci;
      @(negedge clk);
      in_valid = 1'b0;
      wait_ov(lat, irbad);
   endtask
   task automatic release16();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("release out_valid", 32'(out_valid), 0);
      check("release in_ready", 32'(in_ready), 1);
   endtask
   // each width gets its own DUT, reset and scoreboard running alongside the directed tests
   for (genvar g = 0; g < 3; g++) begin : gen_rnd
      localparam int W = g == 0 ? 2 : g == 1 ? 8 : 16;
      logic rn, iv, ir, ci, ov, ordy, co;
      logic [W-1:0] x, y, s;
      logic [W:0] q[$];
      logic [W:0] e;
      int acc_n, got_n, cyc;
      bit done_g = 1'b0;
      bit extra;
      ksa2_digit_serial_adder #(.WIDTH(W)) u_dut (
         .clk(clk), .rst_n(rn), .in_valid(iv), .in_ready(ir),
         .a(x), .b(y), .cin(ci), .out_valid(ov), .out_ready(ordy),
         .sum(s), .cout(co)
      );
      initial begin
         rn = 1'b0;
         iv = 1'b0;
         ordy = 1'b0;
         x = '0;
         y = '0;
         ci = 1'b0;
         acc_n = 0;
         got_n = 0;
         cyc = 0;
         repeat (2) @(negedge clk);
         rn = 1'b1;
         while ((acc_n < NRND || q.size() != 0) && cyc < 60000) begin
            iv = acc_n < NRND ? ($urandom_range(0, 9) < 7) : 1'b0;
            x = W'($urandom);
            y = W'($urandom);
            ci = 1'($urandom);
            ordy = 1'($urandom);
            if (iv && ir) begin
               q.push_back((W+1)'(x) + (W+1)'(y) + (W+1)'(ci));
               acc_n++;
            end
            if (ov && ordy) begin
               if (q.size() == 0) check($sformatf("w%0d duplicate result", W), 1, 0);
               else begin
                  e = q.pop_front();
                  check($sformatf("w%0d result", W), 32'({co, s}), 32'(e));
               end
               got_n++;
            end
            @(negedge clk);
            cyc++;
         end
         iv = 1'b0;
         ordy = 1'b1;
         extra = 1'b0;
         repeat (W + 4) begin
            if (ov) extra = 1'b1;
            @(negedge clk);
         end
         check($sformatf("w%0d results count", W), 32'(got_n), 32'(NRND));
         check($sformatf("w%0d pending", W), 32'(q.size()), 0);
         check($sformatf("w%0d spurious", W), 32'(extra), 0);
         done_g = 1'b1;
      end
   end
   initial begin
      #3ms;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end
   initial begin
      int lat;
      bit irbad, seen;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      repeat (2) @(negedge clk);
      check("reset in_ready", 32'(in_ready), 1);
      check("reset out_valid", 32'(out_valid), 0);
      check("reset sum", 32'(sum), 0);
      check("reset cout", 32'(cout), 0);
      rst_n = 1'b1;
      @(negedge clk);
      op16(16'hFFFF, 16'h0001, 1'b0, lat, irbad);
      check("ffff+1 sum", 32'(sum), 0);
      check("ffff+1 cout", 32'(cout), 1);
      check("ffff+1 latency", 32'(lat), 8);
      check("ffff+1 in_ready busy", 32'(irbad), 0);
      release16();
      op16(16'h1234, 16'h4321, 1'b1, lat, irbad);
      check("1234+4321+1 sum", 32'(sum), 32'h5556);
      check("1234+4321+1 cout", 32'(cout), 0);
      repeat (5) begin
         @(negedge clk);
         check("hold out_valid", 32'(out_valid), 1);
         check("hold sum", 32'(sum), 32'h5556);
         check("hold cout", 32'(cout), 0);
      end
      release16();
      op16(16'h8000, 16'h8000, 1'b0, lat, irbad);
      check("8000+8000 sum", 32'(sum), 0);
      check("8000+8000 cout", 32'(cout), 1);
      release16();
      op16(16'hAAAA, 16'h5555, 1'b1, lat, irbad);
      check("aaaa+5555+1 sum", 32'(sum), 0);
      check("aaaa+5555+1 cout", 32'(cout), 1);
      release16();
      in_valid = 1'b1;
      a = 16'h0001;
      b = 16'h0001;
      cin = 1'b0;
      @(negedge clk);
      a = 16'hFFFF;
      b = 16'hFFFF;
      wait_ov(lat, irbad);
      check("inflight first sum", 32'(sum), 2);
      check("inflight first cout", 32'(cout), 0);
      check("inflight first latency", 32'(lat), 8);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("inflight idle in_ready", 32'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      wait_ov(lat, irbad);
      check("inflight second sum", 32'(sum), 32'hFFFE);
      check("inflight second cout", 32'(cout), 1);
      release16();
      in_valid = 1'b1;
      a = 16'hFFFF;
      b = 16'h0001;
      cin = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrun reset out_valid", 32'(out_valid), 0);
      check("midrun reset sum", 32'(sum), 0);
      check("midrun reset cout", 32'(cout), 0);
      check("midrun reset in_ready", 32'(in_ready), 1);
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("midrun reset spurious", 32'(seen), 0);
      op16(16'h0003, 16'h0005, 1'b0, lat, irbad);
      check("3+5 sum", 32'(sum), 8);
      check("3+5 cout", 32'(cout), 0);
      release16();
      wait (gen_rnd[0].done_g && gen_rnd[1].done_g && gen_rnd[2].done_g);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
